// File: rtl/minmax_pkg.sv
// Shared types and the midrange helper for the min/max/midrange engine.
package minmax_pkg;

  // Widest sample the midrange helper supports; callers zero-extend into it.
  localparam int MAX_W = 32;

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    HOLD
  } state_e;

  typedef enum logic {
    CMP_MIN,
    CMP_MAX
  } cmp_mode_e;

  // Sum carries one extra bit so an all-ones pair never wraps before the shift.
  function automatic logic [MAX_W-1:0] midrange(input logic [MAX_W-1:0] a,
                                                input logic [MAX_W-1:0] b,
                                                input logic             round);
    logic [MAX_W:0] sum;
    sum = {1'b0, a} + {1'b0, b} + {{MAX_W{1'b0}}, round};
    return sum[MAX_W:1];
  endfunction

endpackage

// File: rtl/minmax_cmp.sv
// Decides whether a new sample replaces the running min or max register.
module minmax_cmp
  import minmax_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] sample_i,
  input  logic [WIDTH-1:0] cur_i,
  input  logic             first_i,
  input  cmp_mode_e        mode_i,
  output logic             take_o
);

  // Strict comparisons: a tie keeps the register as it is.
  always_comb begin
    take_o = first_i;
    if (!first_i) begin
      take_o = (mode_i == CMP_MIN) ? (sample_i < cur_i) : (sample_i > cur_i);
    end
  end

endmodule

// File: rtl/minmax_midrange.sv
// Streaming engine: collects COUNT samples, then holds min, max and midrange
// on a valid/ready output until the consumer takes them.
module minmax_midrange
  import minmax_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int COUNT = 8,
  parameter int ROUND = 0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_min,
  output logic [WIDTH-1:0] out_max,
  output logic [WIDTH-1:0] out_avg,
  output logic             busy,
  output state_e           dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid && ready;
  // valid never depends combinationally on ready on either side.

  localparam int             CW   = $clog2(COUNT + 1);
  localparam logic [CW-1:0]  LAST = CW'(COUNT - 1);

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] min_q, min_d;
  logic [WIDTH-1:0] max_q, max_d;
  logic [WIDTH-1:0] omin_q, omin_d;
  logic [WIDTH-1:0] omax_q, omax_d;
  logic [WIDTH-1:0] oavg_q, oavg_d;
  logic             first;
  logic             accept;
  logic             take_min;
  logic             take_max;

  assign first  = (cnt_q == '0);
  assign accept = in_valid && (state_q == COLLECT);

  minmax_cmp #(.WIDTH(WIDTH)) u_cmp_min (
    .sample_i (in_data),
    .cur_i    (min_q),
    .first_i  (first),
    .mode_i   (CMP_MIN),
    .take_o   (take_min)
  );

  minmax_cmp #(.WIDTH(WIDTH)) u_cmp_max (
    .sample_i (in_data),
    .cur_i    (max_q),
    .first_i  (first),
    .mode_i   (CMP_MAX),
    .take_o   (take_max)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    min_d   = min_q;
    max_d   = max_q;
    omin_d  = omin_q;
    omax_d  = omax_q;
    oavg_d  = oavg_q;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (start) state_d = COLLECT;
      end
      COLLECT: begin
        if (accept) begin
          cnt_d = cnt_q + 1'b1;
          if (take_min) min_d = in_data;
          if (take_max) max_d = in_data;
          // Result registers only change on the closing accept, so the
          // previous frame's answer stays visible while collecting.
          if (cnt_q == LAST) begin
            state_d = HOLD;
            omin_d  = min_d;
            omax_d  = max_d;
            oavg_d  = WIDTH'(midrange(MAX_W'(min_d), MAX_W'(max_d), ROUND != 0));
          end
        end
      end
      HOLD: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      min_q   <= '0;
      max_q   <= '0;
      omin_q  <= '0;
      omax_q  <= '0;
      oavg_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      min_q   <= min_d;
      max_q   <= max_d;
      omin_q  <= omin_d;
      omax_q  <= omax_d;
      oavg_q  <= oavg_d;
    end
  end

  assign in_ready  = (state_q == COLLECT);
  assign out_valid = (state_q == HOLD);
  assign busy      = (state_q != IDLE);
  assign out_min   = omin_q;
  assign out_max   = omax_q;
  assign out_avg   = oavg_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_minmax_midrange.sv
// Bench for minmax_midrange: floor and round-half-up 8x8 engines driven in
// lockstep, plus a 12-bit single-sample engine, checked through result queues.
module tb_minmax_midrange;
  import minmax_pkg::*;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  // Shared stimulus for the two 8x8 instances
  logic       start, in_valid, out_ready;
  logic [7:0] in_data;
  logic       in_ready0, out_valid0, busy0, in_ready1, out_valid1, busy1;
  logic [7:0] min0, max0, avg0, min1, max1, avg1;
  state_e     st0, st1;

  // 12-bit, one-sample instance
  logic        start2, in_valid2, out_ready2;
  logic [11:0] in_data2;
  logic        in_ready2, out_valid2, busy2;
  logic [11:0] min2, max2, avg2;
  state_e      st2;

  minmax_midrange #(.WIDTH(8), .COUNT(8), .ROUND(0)) dut0 (
    .clock(clock), .reset(reset), .start(start), .in_valid(in_valid),
    .in_data(in_data), .in_ready(in_ready0), .out_valid(out_valid0),
    .out_ready(out_ready), .out_min(min0), .out_max(max0), .out_avg(avg0),
    .busy(busy0), .dbg_state(st0)
  );

  minmax_midrange #(.WIDTH(8), .COUNT(8), .ROUND(1)) dut1 (
    .clock(clock), .reset(reset), .start(start), .in_valid(in_valid),
    .in_data(in_data), .in_ready(in_ready1), .out_valid(out_valid1),
    .out_ready(out_ready), .out_min(min1), .out_max(max1), .out_avg(avg1),
    .busy(busy1), .dbg_state(st1)
  );

  minmax_midrange #(.WIDTH(12), .COUNT(1), .ROUND(0)) dut2 (
    .clock(clock), .reset(reset), .start(start2), .in_valid(in_valid2),
    .in_data(in_data2), .in_ready(in_ready2), .out_valid(out_valid2),
    .out_ready(out_ready2), .out_min(min2), .out_max(max2), .out_avg(avg2),
    .busy(busy2), .dbg_state(st2)
  );

  logic [23:0] exp_q0[$];
  logic [23:0] exp_q1[$];
  logic [35:0] exp_q2[$];
  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: min and max by scanning the frame, midrange by integer division.
  function automatic logic [23:0] ref8(input logic [7:0] s[8], input int r);
    int mn, mx;
    mn = s[0];
    mx = s[0];
    for (int i = 1; i < 8; i++) begin
      if (s[i] < mn) mn = s[i];
      if (s[i] > mx) mx = s[i];
    end
    return {8'(mn), 8'(mx), 8'((mn + mx + r) / 2)};
  endfunction

  // Monitors: every HOLD cycle must show the head of the queue; pop on handshake.
  always @(negedge clock) begin
    if (!reset && out_valid0) begin
      if (exp_q0.size() == 0) chk("dut0_unexpected_valid", 1, 0);
      else begin
        chk("dut0_result", {min0, max0, avg0}, exp_q0[0]);
        if (out_ready) void'(exp_q0.pop_front());
      end
    end
    if (!reset && out_valid1) begin
      if (exp_q1.size() == 0) chk("dut1_unexpected_valid", 1, 0);
      else begin
        chk("dut1_result", {min1, max1, avg1}, exp_q1[0]);
        if (out_ready) void'(exp_q1.pop_front());
      end
    end
    if (!reset && out_valid2) begin
      if (exp_q2.size() == 0) chk("dut2_unexpected_valid", 1, 0);
      else begin
        chk("dut2_result", {min2, max2, avg2}, exp_q2[0]);
        if (out_ready2) void'(exp_q2.pop_front());
      end
    end
  end

  task automatic check_reset_values();
    chk("rst_in_ready", {in_ready0, in_ready1, in_ready2}, 0);
    chk("rst_out_valid", {out_valid0, out_valid1, out_valid2}, 0);
    chk("rst_busy", {busy0, busy1, busy2}, 0);
    chk("rst_outputs8", {min0, max0, avg0, min1, max1, avg1}, 0);
    chk("rst_outputs12", {min2, max2, avg2}, 0);
    chk("rst_state", st0, IDLE);
  endtask

  // Drives one frame on the shared bus. abort_after < 8 resets mid-frame.
  task automatic run_frame(input logic [7:0] s[8], input bit gaps, input bit start_collect,
                           input bit start_idle_valid, input int abort_after);
    start = 1'b1;
    if (start_idle_valid) begin
      in_valid = 1'b1;
      in_data  = 8'h00;
    end
    @(posedge clock); #1;
    start    = 1'b0;
    in_valid = 1'b0;
    chk("start_in_ready", in_ready0, 1);
    chk("start_busy", {busy0, busy1}, 2'b11);
    chk("start_state", st0, COLLECT);
    for (int i = 0; i < 8; i++) begin
      if (i == abort_after) begin
        #1 reset = 1'b1;
        #1 check_reset_values();
        @(posedge clock); #1 reset = 1'b0;
        return;
      end
      if (gaps) begin
        int g;
        g = $urandom_range(0, 3);
        repeat (g) begin
          @(posedge clock); #1;
          chk("gap_no_valid", out_valid0, 0);
        end
      end
      in_valid = 1'b1;
      in_data  = s[i];
      if (start_collect && i == 3) start = 1'b1;
      begin
        int b;
        b = 0;
        while (!in_ready0 && b < 20) begin
          @(posedge clock); #1;
          b++;
        end
        if (b == 20) chk("accept_timeout", 0, 1);
      end
      @(posedge clock); #1;
      in_valid = 1'b0;
      start    = 1'b0;
    end
    exp_q0.push_back(ref8(s, 0));
    exp_q1.push_back(ref8(s, 1));
    chk("latency_out_valid", {out_valid0, out_valid1}, 2'b11);
  endtask

  // Holds out_ready low for hold_low cycles (optionally pulsing start), then takes the result.
  task automatic drain(input int hold_low, input bit start_in_hold);
    out_ready = 1'b0;
    for (int k = 0; k < hold_low; k++) begin
      if (start_in_hold) start = 1'b1;
      @(posedge clock); #1;
      start = 1'b0;
      chk("hold_valid", out_valid0, 1);
    end
    out_ready = 1'b1;
    @(posedge clock); #1;
    out_ready = 1'b0;
    chk("after_hs_busy", {busy0, busy1}, 0);
    chk("after_hs_valid", {out_valid0, out_valid1}, 0);
    @(posedge clock); #1;
    chk("no_restart", {busy0, in_ready0}, 0);
  endtask

  logic [7:0] fr[8];
  logic [11:0] s12;

  initial begin
    start = 0; in_valid = 0; in_data = 0; out_ready = 0;
    start2 = 0; in_valid2 = 0; in_data2 = 0; out_ready2 = 0;
    #2 check_reset_values();
    @(posedge clock); #1 reset = 1'b0;

    fr = '{8'd5, 8'd200, 8'd17, 8'd3, 8'd99, 8'd250, 8'd42, 8'd10};
    run_frame(fr, 0, 0, 0, 8);
    chk("plan_floor", {min0, max0, avg0}, {8'd3, 8'd250, 8'd126});
    chk("plan_round", avg1, 127);
    drain(0, 0);

    fr = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
    run_frame(fr, 0, 0, 0, 8);
    chk("plan_all_ff", {min1, max1, avg1}, 24'hFFFFFF);
    drain(1, 0);

    for (int i = 0; i < 8; i++) fr[i] = 8'($urandom_range(0, 255));
    run_frame(fr, 1, 1, 0, 8);
    drain(5, 1);

    for (int i = 0; i < 8; i++) fr[i] = 8'($urandom_range(1, 255));
    run_frame(fr, 0, 0, 1, 8);
    drain(2, 0);

    for (int i = 0; i < 8; i++) fr[i] = 8'($urandom_range(0, 255));
    run_frame(fr, 1, 0, 0, 4);

    fr = '{8'd9, 8'd9, 8'd1, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
    for (int i = 3; i < 8; i++) fr[i] = 8'($urandom_range(1, 255));
    run_frame(fr, 0, 0, 0, 8);
    chk("post_reset_min", min0, 1);
    drain(3, 0);

    for (int f = 0; f < 20; f++) begin
      for (int i = 0; i < 8; i++) fr[i] = 8'($urandom_range(0, 255));
      run_frame(fr, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)), 8);
      drain($urandom_range(0, 6), 1'($urandom_range(0, 1)));
    end

    for (int k = 0; k < 6; k++) begin
      s12 = (k == 0) ? 12'hABC : 12'($urandom_range(0, 4095));
      start2 = 1'b1;
      @(posedge clock); #1 start2 = 1'b0;
      chk("d2_in_ready", in_ready2, 1);
      in_valid2 = 1'b1;
      in_data2  = s12;
      @(posedge clock); #1 in_valid2 = 1'b0;
      exp_q2.push_back({s12, s12, s12});
      chk("d2_latency", out_valid2, 1);
      out_ready2 = 1'b1;
      @(posedge clock); #1 out_ready2 = 1'b0;
      chk("d2_after_hs_busy", busy2, 0);
    end

    @(posedge clock); #1;
    chk("queues_drained", exp_q0.size() + exp_q1.size() + exp_q2.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/minmax_midrange.md
# minmax_midrange

Streaming min/max/midrange engine. It captures a frame of `COUNT` unsigned samples over a valid/ready input. It reports the smallest sample, the largest sample and their average, `(min+max)/2`, on a valid/ready output. Width, frame length and rounding are set by parameters. It is the handshaked, parametrised successor to the fixed 8-byte average block in the datapath.

## Interface
- `WIDTH`, default 8: sample width in bits, at least 2.
- `COUNT`, default 8: samples per frame, at least 1.
- `ROUND`, default 0: 0 = floor average; 1 = round half up.
- `clock`, in, 1: rising-edge clock.
- `reset`, in, 1: asynchronous, active-high.
- `start`, in, 1: one-cycle pulse that opens a frame. Honoured only in IDLE.
- `in_valid`, in, 1: sample present.
- `in_data`, in, WIDTH: unsigned sample.
- `in_ready`, out, 1: block accepts a sample.
- `out_valid`, out, 1: result available.
- `out_ready`, in, 1: consumer accepts the result.
- `out_min`, out, WIDTH: smallest sample of the frame.
- `out_max`, out, WIDTH: largest sample of the frame.
- `out_avg`, out, WIDTH: midrange of the frame.
- `busy`, out, 1: state is not IDLE.

## Operation
- Reset and clock: reset is asynchronous, active-high; clock is `clock`.
- States:
  - IDLE: `start` moves to COLLECT. A sample-counter `cnt` (width `$clog2(COUNT+1)`) is cleared.
  - COLLECT: a sample is accepted when `in_valid && in_ready`, and `cnt` increments on each accept.
    - The first sample loads both `min_r` and `max_r`.
    - Later samples are compared unsigned. `min_r` updates if sample < `min_r`; `max_r` updates if sample > `max_r`. Ties leave the registers unchanged.
    - The accept that makes `cnt == COUNT` moves to HOLD.
  - HOLD: `out_valid = 1`. When `out_valid && out_ready`, move to IDLE.
- Outputs in HOLD:
  - `out_min` and `out_max` present the final registers.
  - `out_avg = (min + max + ROUND) >> 1`. The sum is computed in WIDTH+1 bits; the result always fits in WIDTH bits.
- `in_ready = 1` only in COLLECT.
- `start` seen in COLLECT or HOLD is ignored. It is not queued.
- The block has no error or abort path. A frame ends only after `COUNT` accepted samples.

## Timing
- Reset values: `in_ready = 0`, `out_valid = 0`, `busy = 0`, `out_min = out_max = out_avg = 0`. State is IDLE and `cnt = 0`.
- `start` asserted at cycle t (in IDLE): `in_ready` and `busy` are 1 from t+1.
- `start` and `in_valid` in the same IDLE cycle: the sample is not accepted, because `in_ready` is 0.
- Last sample accepted at edge t: `out_valid = 1` and outputs are stable from t+1. This is 1-cycle latency.
- `in_valid` gaps are allowed. `cnt` and the registers hold while `in_valid = 0`.
- `out_ready` low holds `out_valid` and all three outputs constant, with no limit.
- Handshake at edge t in HOLD: `out_valid = 0` and `busy = 0` at t+1. A new `start` is honoured from t+1. Outputs keep their last values until the next frame's HOLD.
- `COUNT = 1`: the single accept moves directly to HOLD with min = max = avg = sample.
- `reset` mid-frame: immediate return to IDLE with all reset values. The partial frame is discarded.

## Structure
- `minmax_pkg`:
  - state enum `{IDLE, COLLECT, HOLD}`;
  - helper function `midrange(a, b, round)` returning WIDTH bits.
- Sub-module `minmax_cmp`, parametrised by WIDTH, instantiated twice (min path and max path):
  - inputs: sample, current register, `first`, `mode`;
  - output: `take`, meaning load the sample.
- Top level: FSM, counter, registers and output mux. Estimated 150–250 lines total.

## Test plan
- WIDTH=8, COUNT=8, ROUND=0; samples 5,200,17,3,99,250,42,10 with no gaps. Required: `out_min = 3`, `out_max = 250`, `out_avg = 126`, `out_valid` one cycle after the 8th accept.
- Same frame with ROUND=1. Required: `out_avg = 127`. All 8 samples = 0xFF. Required: `out_min = out_max = out_avg = 255`, showing no overflow.
- Random `in_valid` gaps, plus `out_ready` held low 5 cycles in HOLD. Required: outputs and `out_valid` constant throughout, handshake returns to IDLE, `busy` drops the next cycle.
- `start` pulsed during COLLECT and during HOLD. Required: ignored, no restart, frame result unchanged. `start` with `in_valid` in IDLE: that sample is not counted.
- Assert `reset` after 4 of 8 samples. Required: all outputs 0 and IDLE immediately. A fresh frame 9,9,1,… then produces correct results, unaffected by the discarded samples.
- COUNT=1, WIDTH=12, sample 0xABC. Required: min = max = avg = 0xABC with 1-cycle latency.
